control_calculadora: RTL

//  Sequencing FSM for the calculator datapath. It takes decoded keypad codes and builds operand A
//  (decimal accumulation), accepts an operator, then builds operand B. It launches the ALU, latches
//  the result and drives the display value. It also rejects keys that are illegal in the current state.

---
 rtl/control_calculadora_pkg.sv | 37 +++
 rtl/control_calculadora_if.sv | 28 ++
 rtl/control_calculadora_acumulador_decimal.sv | 51 +++++
 rtl/control_calculadora.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/control_calculadora_pkg.sv
// Key codes, state/operator enums and key classifiers for the calculator controller.
package calc_pkg;

   localparam logic [3:0] TECLA_SUMA   = 4'hE;
   localparam logic [3:0] TECLA_RESTA  = 4'hF;
   localparam logic [3:0] TECLA_IGUAL  = 4'hC;
   localparam logic [3:0] TECLA_BORRAR = 4'hD;

   localparam int IDX_A = 0;
   localparam int IDX_B = 1;

   typedef enum logic [2:0] {
      S_OP1,
      S_OPERADOR,
      S_OP2,
      S_CALC,
      S_RESULTADO
   } estado_t;

   typedef enum logic {
      OP_SUMA  = 1'b0,
      OP_RESTA = 1'b1
   } op_t;

   function automatic logic es_digito(input logic [3:0] codigo);
      return codigo <= 4'd9;
   endfunction

   function automatic logic es_operador(input logic [3:0] codigo);
      return (codigo == TECLA_SUMA) || (codigo == TECLA_RESTA);
   endfunction

   function automatic op_t decodifica_op(input logic [3:0] codigo);
      return (codigo == TECLA_RESTA) ? OP_RESTA : OP_SUMA;
   endfunction

endpackage

// File: rtl/control_calculadora_if.sv
// Keypad / ALU / display signal bundle of the calculator controller.
interface control_calculadora_if #(
   parameter int ANCHO = 14
);
   logic                    tecla_valida;
   logic [3:0]              numero_traducido;
   logic                    alu_listo;
   logic signed [ANCHO:0]   alu_resultado;
   logic [ANCHO-1:0]        operando_a;
   logic [ANCHO-1:0]        operando_b;
   logic                    operador;
   logic                    inicio_calculo;
   logic signed [ANCHO:0]   valor_display;
   logic                    esperando_operador;
   logic                    tecla_rechazada;

   modport master (
      output tecla_valida, numero_traducido, alu_listo, alu_resultado,
      input  operando_a, operando_b, operador, inicio_calculo,
      input  valor_display, esperando_operador, tecla_rechazada
   );

   modport slave (
      input  tecla_valida, numero_traducido, alu_listo, alu_resultado,
      output operando_a, operando_b, operador, inicio_calculo,
      output valor_display, esperando_operador, tecla_rechazada
   );
endinterface

// File: rtl/control_calculadora_acumulador_decimal.sv
// Decimal operand accumulator: clear, parallel load, or shift in one decimal digit (acc*10+d).
module acumulador_decimal #(
   parameter  int MAX_DIGITOS = 4,
   parameter  int ANCHO       = 14,
   localparam int CW          = $clog2(MAX_DIGITOS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             borrar,
   input  logic             cargar,
   input  logic [ANCHO-1:0] valor_carga,
   input  logic [CW-1:0]    cuenta_carga,
   input  logic             meter_digito,
   input  logic [3:0]       digito,
   output logic [ANCHO-1:0] valor,
   output logic [CW-1:0]    cuenta,
   output logic             lleno
);
   logic [ANCHO-1:0] valor_reg, valor_next;
   logic [CW-1:0]    cuenta_reg, cuenta_next;

   assign lleno  = (cuenta_reg == CW'(MAX_DIGITOS));
   assign valor  = valor_reg;
   assign cuenta = cuenta_reg;

   always_comb begin
      valor_next  = valor_reg;
      cuenta_next = cuenta_reg;
      if (borrar) begin
         valor_next  = '0;
         cuenta_next = '0;
      end else if (cargar) begin
         valor_next  = valor_carga;
         cuenta_next = cuenta_carga;
      end else if (meter_digito && !lleno) begin
         // x*10 as x*8 + x*2; cannot overflow while the digit count is below the limit
         valor_next  = (valor_reg << 3) + (valor_reg << 1) + {{(ANCHO-4){1'b0}}, digito};
         cuenta_next = cuenta_reg + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valor_reg  <= '0;
         cuenta_reg <= '0;
      end else begin
         valor_reg  <= valor_next;
         cuenta_reg <= cuenta_next;
      end
   end
endmodule

// File: rtl/control_calculadora.sv
// Calculator sequencing FSM: builds operands A/B from keys, launches the ALU and drives the display.
// Optional CALC_ENCADENADO_EN: an operator after a non-negative result chains it into operand A.
module control_calculadora
   import calc_pkg::*;
#(
   parameter int MAX_DIGITOS = 4,
   parameter int ANCHO       = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   control_calculadora_if.slave bus
);
   localparam int CW = $clog2(MAX_DIGITOS + 1);

   estado_t state_reg, state_next;

   logic [1:0]       acc_borrar, acc_cargar, acc_meter, acc_lleno;
   logic [ANCHO-1:0] acc_valor_carga [2];
   logic [ANCHO-1:0] acc_valor       [2];
   logic [CW-1:0]    acc_cuenta_carga[2];
   logic [CW-1:0]    acc_cuenta      [2];

   logic [3:0]            numero;
   logic [ANCHO-1:0]      digito_ext;
   logic                  op_cargar, res_cargar, borrar_todo, rechazo;
   op_t                   operador_reg;
   logic signed [ANCHO:0] resultado_reg, display_hold_reg, display;
   logic                  rechazo_reg, en_calc_prev_reg;

   assign numero     = bus.numero_traducido;
   assign digito_ext = {{(ANCHO-4){1'b0}}, numero};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_acc
         acumulador_decimal #(
            .MAX_DIGITOS(MAX_DIGITOS),
            .ANCHO      (ANCHO)
         ) u_acc (
            .clk         (clk),
            .rst         (rst),
            .borrar      (acc_borrar[gi]),
            .cargar      (acc_cargar[gi]),
            .valor_carga (acc_valor_carga[gi]),
            .cuenta_carga(acc_cuenta_carga[gi]),
            .meter_digito(acc_meter[gi]),
            .digito      (numero),
            .valor       (acc_valor[gi]),
            .cuenta      (acc_cuenta[gi]),
            .lleno       (acc_lleno[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_OP1;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next                = state_reg;
      acc_borrar                = '0;
      acc_cargar                = '0;
      acc_meter                 = '0;
      acc_valor_carga[IDX_A]    = '0;
      acc_valor_carga[IDX_B]    = '0;
      acc_cuenta_carga[IDX_A]   = '0;
      acc_cuenta_carga[IDX_B]   = '0;
      op_cargar                 = 1'b0;
      res_cargar                = 1'b0;
      borrar_todo               = 1'b0;
      rechazo                   = 1'b0;

      // Clear beats everything, including a result arriving the same cycle
      if (bus.tecla_valida && numero == TECLA_BORRAR) begin
         state_next  = S_OP1;
         acc_borrar  = 2'b11;
         borrar_todo = 1'b1;
      end else begin
         case (state_reg)
            S_OP1: if (bus.tecla_valida) begin
               if (es_digito(numero) && !acc_lleno[IDX_A]) begin
                  acc_meter[IDX_A] = 1'b1;
                  if (acc_cuenta[IDX_A] == CW'(MAX_DIGITOS - 1)) state_next = S_OPERADOR;
               end else if (es_operador(numero) && acc_cuenta[IDX_A] != '0) begin
                  op_cargar  = 1'b1;
                  state_next = S_OP2;
               end else begin
                  rechazo = 1'b1;
               end
            end
            S_OPERADOR: if (bus.tecla_valida) begin
               if (es_operador(numero)) begin
                  op_cargar  = 1'b1;
                  state_next = S_OP2;
               end else begin
                  rechazo = 1'b1;
               end
            end
            S_OP2: if (bus.tecla_valida) begin
               if (es_digito(numero) && !acc_lleno[IDX_B]) begin
                  acc_meter[IDX_B] = 1'b1;
               end else if (numero == TECLA_IGUAL && acc_cuenta[IDX_B] != '0) begin
                  state_next = S_CALC;
               end else begin
                  rechazo = 1'b1;
               end
            end
            S_CALC: begin
               rechazo = bus.tecla_valida;
               if (bus.alu_listo) begin
                  res_cargar = 1'b1;
                  state_next = S_RESULTADO;
               end
            end
            S_RESULTADO: if (bus.tecla_valida) begin
               if (es_digito(numero)) begin
                  acc_cargar[IDX_A]       = 1'b1;
                  acc_valor_carga[IDX_A]  = digito_ext;
                  acc_cuenta_carga[IDX_A] = CW'(1);
                  acc_borrar[IDX_B]       = 1'b1;
                  state_next              = S_OP1;
               end
`ifdef CALC_ENCADENADO_EN
               else if (es_operador(numero) && !resultado_reg[ANCHO]) begin
                  acc_cargar[IDX_A]       = 1'b1;
                  acc_valor_carga[IDX_A]  = resultado_reg[ANCHO-1:0];
                  acc_cuenta_carga[IDX_A] = CW'(MAX_DIGITOS);
                  acc_borrar[IDX_B]       = 1'b1;
                  op_cargar               = 1'b1;
                  state_next              = S_OP2;
               end
`endif
               else begin
                  rechazo = 1'b1;
               end
            end
            default: state_next = S_OP1;
         endcase
      end
   end

   always_comb begin
      display = display_hold_reg;
      case (state_reg)
         S_OP1, S_OPERADOR: display = {1'b0, acc_valor[IDX_A]};
         S_OP2:             display = (acc_cuenta[IDX_B] != '0) ? {1'b0, acc_valor[IDX_B]}
                                                                : {1'b0, acc_valor[IDX_A]};
         S_RESULTADO:       display = resultado_reg;
         default:           display = display_hold_reg;
      endcase

      bus.valor_display      = display;
      bus.operando_a         = acc_valor[IDX_A];
      bus.operando_b         = acc_valor[IDX_B];
      bus.operador           = operador_reg;
      bus.esperando_operador = (state_reg == S_OPERADOR);
      bus.inicio_calculo     = (state_reg == S_CALC) && !en_calc_prev_reg;
      bus.tecla_rechazada    = rechazo_reg;
   end

   // display_hold_reg tracks the shown value so S_CALC can keep showing it
   always_ff @(posedge clk) begin
      if (rst) begin
         operador_reg     <= OP_SUMA;
         resultado_reg    <= '0;
         display_hold_reg <= '0;
         rechazo_reg      <= 1'b0;
         en_calc_prev_reg <= 1'b0;
      end else begin
         rechazo_reg      <= rechazo;
         en_calc_prev_reg <= (state_reg == S_CALC);
         display_hold_reg <= display;
         if (borrar_todo) begin
            operador_reg  <= OP_SUMA;
            resultado_reg <= '0;
         end else begin
            if (op_cargar)  operador_reg  <= decodifica_op(numero);
            if (res_cargar) resultado_reg <= bus.alu_resultado;
         end
      end
   end
endmodule
